spi_xip_seq: RTL and testbench
==============================

Name: spi_xip_seq

Overview:
- XIP read sequencer for the SPI flash window 0x3000_0000–0x3FFF_FFFF.
- Takes one word-read request at a time from the flash-window decode logic.
- Acts as an APB master to the SPI master core's register file and runs the full register program for one flash read (cmd 0x03).
- Returns the byte-swapped 32-bit word upstream. Replaces the stalled XIP_INIT path of the SPI APB wrapper.

Parameters:
- SPI_BASE, 32'h1000_1000, APB base of the SPI core register file.
- DIVIDER, 32'h0000_0001, value written to the DIVIDER register (0x14).
- CTRL_CFG, 32'h0000_2440, CTRL value without GO: ASS=1, TX_NEG=1, CHAR_LEN=64.
- SS_MASK, 8'h01, slave-select bit for the flash.
- POLL_MAX, 16'hFFFF, maximum CTRL poll reads before timeout.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-low (asserted at 0)
- req_valid  input  1  flash read request
- req_ready  output  1  sequencer idle and accepting a request
- req_addr  input  32  byte address inside the flash window
- req_write  input  1  request is a write (unsupported)
- rsp_valid  output  1  response valid, one-cycle pulse
- rsp_data  output  32  read word, little-endian
- rsp_err  output  1  response error
- out_paddr  output  32  APB master address
- out_psel  output  1  APB select
- out_penable  output  1  APB enable
- out_pwrite  output  1  APB write
- out_pwdata  output  32  APB write data
- out_pstrb  output  4  APB strobe (always 4'hF on writes, 0 on reads)
- out_pready  input  1  APB ready from the SPI core
- out_prdata  input  32  APB read data
- out_pslverr  input  1  APB error

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All out_* = 0; rsp_valid=0, rsp_data=0, rsp_err=0; poll counter=0.
  - req_ready=1 once reset is released.
- Handshake:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - addr is latched as {req_addr[23:2], 2'b00}.
  - req_ready=0 from the acceptance cycle until the cycle after rsp_valid.
- Write requests: req_write=1 goes to RESP with rsp_err=1 and rsp_data=0. rsp_valid asserts 1 cycle after acceptance; no APB traffic.
- Every APB access is two-phase:
  - SETUP: psel=1, penable=0, for exactly 1 cycle.
  - ACCESS: psel=1, penable=1, held until out_pready=1.
  - Address, write, wdata and strb are stable across both phases.
  - psel drops the cycle after pready.
  - The next access's SETUP is issued immediately on the following cycle (no idle gap required).
- Read-access states, in order (addresses relative to SPI_BASE):
  1. W_DIV: write 0x14 = DIVIDER.
  2. W_SS: write 0x18 = {24'b0, SS_MASK}.
  3. W_TX1: write 0x04 = {8'h03, addr[23:0]}.
  4. W_CTRL: write 0x10 = CTRL_CFG | 32'h100 (GO).
  5. R_POLL: read 0x10.
     - If prdata[8]=1, reissue R_POLL and increment the counter.
     - If prdata[8]=0, go to R_RX.
     - When the counter reaches POLL_MAX, go to W_SSCLR with the error flag set.
  6. R_RX: read 0x00 and capture prdata.
  7. W_SSCLR: write 0x18 = 0.
  8. RESP.
- RESP:
  - rsp_valid=1 for 1 cycle.
  - rsp_data = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]}.
  - rsp_err = error flag.
  - Then IDLE.
- pslverr: out_pslverr sampled with pready in any state other than W_SSCLR sets the error flag and jumps to W_SSCLR. SS is always released.
  - pslverr during W_SSCLR: error flag set, proceed to RESP.
- Error responses force rsp_data=0.
- Minimum read latency, acceptance to rsp_valid, with pready=1 in ACCESS and one poll: 7 accesses × 2 cycles + 1 = 15 cycles.
- req_valid while busy is ignored (req_ready=0); the upstream holds the request.
- Reset mid-transaction aborts immediately: APB outputs go to 0 asynchronously and SS is not explicitly cleared. The SPI core is reset by the same system reset.

Test Plan:
- Read 0x3000_0010; core returns pready on the first ACCESS cycle, poll CTRL bit8=1 twice then 0, RX0=0x1122_3344.
  - Required: APB writes in order: 0x1000_1014=1, 0x1000_1018=1, 0x1000_1004=0x0300_0010, 0x1000_1010=0x2540.
  - Then 3 reads of 0x1000_1010, 1 read of 0x1000_1000, write 0x1000_1018=0.
  - rsp_data=0x4433_2211, rsp_err=0.
- Write request to 0x3000_0000 -> no psel activity; rsp_valid 1 cycle after acceptance; rsp_err=1, rsp_data=0.
- pready delayed 3 cycles on every access -> psel/penable/paddr/pwdata held stable through each wait; the same access sequence and result as scenario 1.
- pslverr=1 on the W_TX1 access -> the next access is the write 0x1000_1018=0; then rsp_err=1, rsp_data=0, and no CTRL write occurs.
- CTRL read always returns bit8=1 -> after POLL_MAX+1 poll reads, SS clear is written and rsp_err=1.
- Assert reset=0 during R_POLL -> all outputs go to 0 within the same cycle; after release, req_ready=1 and a fresh read completes correctly.

Source files
------------

// File: rtl/spi_xip_seq.sv
// spi_xip_seq -- XIP read sequencer for the SPI flash window.
//
// Accepts one word-read request at a time from the flash-window decoder and
// turns it into the APB register program of the SPI master core for a single
// flash READ (cmd 0x03). The received word is byte-swapped and returned
// upstream as a one-cycle response pulse.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   req_valid/req_ready   upstream request handshake
//   req_addr, req_write   byte address in the window; writes are rejected
//   rsp_valid             one-cycle response pulse
//   rsp_data, rsp_err     little-endian read word, error flag
//   out_p*                APB master towards the SPI core register file
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only while the FSM is IDLE, so it
// drops from the acceptance edge until the cycle after rsp_valid. The
// upstream holds req_valid/req_addr while req_ready is 0.
module spi_xip_seq #(
  parameter logic [31:0] SPI_BASE = 32'h1000_1000,
  parameter logic [31:0] DIVIDER  = 32'h0000_0001,
  parameter logic [31:0] CTRL_CFG = 32'h0000_2440,
  parameter logic [7:0]  SS_MASK  = 8'h01,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_DIV, S_W_SS, S_W_TX1, S_W_CTRL,
    S_R_POLL, S_R_RX, S_W_SSCLR, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [23:0] addr_q;
  logic [15:0] cnt_q;
  logic [31:0] rx_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_data_q;
  logic [31:0] paddr_q, pwdata_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [3:0]  pstrb_q;

  logic        acc_done, start_acc, poll_busy;
  logic [31:0] nxt_addr, nxt_wdata;
  logic        nxt_wr;

  // Only the 24-bit flash offset (word aligned) is forwarded to the flash.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:24], req_addr[1:0]};

  always_comb begin
    acc_done  = psel_q && penable_q && out_pready;
    poll_busy = out_prdata[8];
    state_d   = state_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_write ? S_RESP : S_W_DIV;
          err_d   = req_write;
        end
      end
      S_W_DIV, S_W_SS, S_W_TX1, S_W_CTRL, S_R_POLL, S_R_RX: begin
        if (acc_done) begin
          if (out_pslverr) begin
            // Any slave error skips straight to releasing SS.
            err_d   = 1'b1;
            state_d = S_W_SSCLR;
          end else begin
            case (state_q)
              S_W_DIV:  state_d = S_W_SS;
              S_W_SS:   state_d = S_W_TX1;
              S_W_TX1:  state_d = S_W_CTRL;
              S_W_CTRL: state_d = S_R_POLL;
              S_R_POLL: begin
                if (!poll_busy) begin
                  state_d = S_R_RX;
                end else if (cnt_q == POLL_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_W_SSCLR;
                end else begin
                  state_d = S_R_POLL;
                end
              end
              default:  state_d = S_W_SSCLR;
            endcase
          end
        end
      end
      S_W_SSCLR: begin
        if (acc_done) begin
          if (out_pslverr) err_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new SETUP phase starts whenever we enter (or re-enter) an access state.
    start_acc = (state_d != S_IDLE) && (state_d != S_RESP) &&
                ((state_q == S_IDLE) || acc_done);

    nxt_addr  = 32'h0;
    nxt_wdata = 32'h0;
    nxt_wr    = 1'b0;
    case (state_d)
      S_W_DIV:   begin nxt_addr = SPI_BASE + 32'h14; nxt_wr = 1'b1; nxt_wdata = DIVIDER; end
      S_W_SS:    begin nxt_addr = SPI_BASE + 32'h18; nxt_wr = 1'b1; nxt_wdata = {24'h0, SS_MASK}; end
      S_W_TX1:   begin nxt_addr = SPI_BASE + 32'h04; nxt_wr = 1'b1; nxt_wdata = {8'h03, addr_q}; end
      S_W_CTRL:  begin nxt_addr = SPI_BASE + 32'h10; nxt_wr = 1'b1; nxt_wdata = CTRL_CFG | 32'h100; end
      S_R_POLL:  begin nxt_addr = SPI_BASE + 32'h10; end
      S_R_RX:    begin nxt_addr = SPI_BASE; end
      S_W_SSCLR: begin nxt_addr = SPI_BASE + 32'h18; nxt_wr = 1'b1; end
      default:   begin nxt_addr = 32'h0; end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      addr_q      <= 24'h0;
      cnt_q       <= 16'h0;
      rx_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rsp_valid_q <= (state_d == S_RESP);

      if (state_q == S_IDLE && req_valid) begin
        addr_q <= {req_addr[23:2], 2'b00};
        cnt_q  <= 16'h0;
        rx_q   <= 32'h0;
      end
      if (acc_done && state_q == S_R_POLL && !out_pslverr && poll_busy && cnt_q != POLL_MAX)
        cnt_q <= cnt_q + 16'h1;
      if (acc_done && state_q == S_R_RX && !out_pslverr)
        rx_q <= out_prdata;

      if (start_acc) begin
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        paddr_q   <= nxt_addr;
        pwrite_q  <= nxt_wr;
        pwdata_q  <= nxt_wdata;
        pstrb_q   <= nxt_wr ? 4'hF : 4'h0;
      end else if (psel_q && !penable_q) begin
        penable_q <= 1'b1;
      end else if (acc_done) begin
        psel_q    <= 1'b0;
        penable_q <= 1'b0;
        paddr_q   <= 32'h0;
        pwrite_q  <= 1'b0;
        pwdata_q  <= 32'h0;
        pstrb_q   <= 4'h0;
      end

      if (state_d == S_RESP) begin
        rsp_err_q  <= err_d;
        rsp_data_q <= err_d ? 32'h0 : {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign out_paddr   = paddr_q;
  assign out_psel    = psel_q;
  assign out_penable = penable_q;
  assign out_pwrite  = pwrite_q;
  assign out_pwdata  = pwdata_q;
  assign out_pstrb   = pstrb_q;

endmodule

// File: tb/tb_spi_xip_seq.sv
// Directed bench for spi_xip_seq with a small APB responder model of the
// SPI core register file (configurable wait states, slave error, CTRL busy).
module tb_spi_xip_seq;

  localparam logic [31:0] BASE = 32'h1000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] out_paddr, out_pwdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [3:0]  out_pstrb;
  logic        out_pready  = 1'b0;
  logic [31:0] out_prdata  = 32'h0;
  logic        out_pslverr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  spi_xip_seq #(.POLL_MAX(16'd3)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // APB responder configuration (written by the main sequence only)
  int          scn = 0;
  int          cfg_delay = 0;
  int          cfg_busy = 0;
  int          cfg_err_idx = -1;
  logic [31:0] cfg_rx = 32'h0;

  // responder state and completed-access log
  int          last_scn = 0;
  int          wcnt = 0, acc_idx = 0, poll_cnt = 0, stab_err = 0;
  logic [31:0] sv_addr = 32'h0, sv_wdata = 32'h0;
  logic        sv_wr = 1'b0;
  logic [3:0]  sv_strb = 4'h0;
  logic [31:0] lg_addr[$];
  logic        lg_wr[$];
  logic [31:0] lg_data[$];

  always @(negedge clock) begin
    if (scn != last_scn) begin
      lg_addr.delete(); lg_wr.delete(); lg_data.delete();
      acc_idx = 0; poll_cnt = 0; stab_err = 0; wcnt = 0;
      last_scn = scn;
    end
    out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = 32'h0;
    if (reset && out_psel && !out_penable) begin
      sv_addr = out_paddr; sv_wdata = out_pwdata; sv_wr = out_pwrite; sv_strb = out_pstrb;
      wcnt = 0;
      if (out_pwrite ? (out_pstrb !== 4'hF) : (out_pstrb !== 4'h0)) stab_err++;
    end else if (reset && out_psel && out_penable) begin
      if (out_paddr !== sv_addr || out_pwdata !== sv_wdata ||
          out_pwrite !== sv_wr || out_pstrb !== sv_strb) stab_err++;
      if (wcnt == cfg_delay) begin
        out_pready = 1'b1;
        if (acc_idx == cfg_err_idx) out_pslverr = 1'b1;
        if (!out_pwrite && out_paddr == BASE + 32'h10) begin
          out_prdata = (poll_cnt < cfg_busy) ? 32'h0000_2540 : 32'h0000_2440;
          poll_cnt++;
        end else if (!out_pwrite && out_paddr == BASE) begin
          out_prdata = cfg_rx;
        end
        lg_addr.push_back(out_paddr);
        lg_wr.push_back(out_pwrite);
        lg_data.push_back(out_pwdata);
        acc_idx++;
      end else begin
        wcnt++;
      end
    end
  end

  // scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (i < lg_addr.size()) begin
      chk($sformatf("acc%0d_addr", i), lg_addr[i], a);
      chk($sformatf("acc%0d_write", i), {31'b0, lg_wr[i]}, {31'b0, w});
      if (w) chk($sformatf("acc%0d_wdata", i), lg_data[i], d);
    end else begin
      chk($sformatf("acc%0d_present", i), lg_addr.size(), i + 1);
    end
  endtask

  // Full read program: 4 setup writes, `polls` CTRL reads, RX read, SS clear.
  task automatic check_read_prog(input logic [31:0] tx1, input int polls);
    chk("acc_count", lg_addr.size(), 7 + polls - 1);
    check_acc(0, BASE + 32'h14, 1'b1, 32'h1);
    check_acc(1, BASE + 32'h18, 1'b1, 32'h1);
    check_acc(2, BASE + 32'h04, 1'b1, tx1);
    check_acc(3, BASE + 32'h10, 1'b1, 32'h2540);
    for (int p = 0; p < polls; p++) check_acc(4 + p, BASE + 32'h10, 1'b0, 32'h0);
    check_acc(4 + polls, BASE, 1'b0, 32'h0);
    check_acc(5 + polls, BASE + 32'h18, 1'b1, 32'h0);
  endtask

  task automatic start_scn(input int id, input int delay, input int busy, input int err_idx,
                           input logic [31:0] rx);
    @(posedge clock); #1;
    scn = id; cfg_delay = delay; cfg_busy = busy; cfg_err_idx = err_idx; cfg_rx = rx;
    @(negedge clock); #1;
  endtask

  // Drive one request and wait (bounded) for its response pulse.
  task automatic run_req(input logic [31:0] a, input logic w, output int lat,
                         output logic [31:0] d, output logic e);
    chk("req_ready_idle", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_addr = a; req_write = w;
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0;
    chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
    lat = 0; d = 32'h0; e = 1'b0;
    while (lat < 500) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) break;
    end
    chk("rsp_seen", {31'b0, rsp_valid}, 32'h1);
    d = rsp_data; e = rsp_err;
    chk("req_ready_in_rsp", {31'b0, req_ready}, 32'h0);
    @(negedge clock);
    chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'h0);
    chk("req_ready_after", {31'b0, req_ready}, 32'h1);
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    logic        e;
    int          found;

    reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_psel", {31'b0, out_psel}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_paddr", out_paddr, 32'h0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_data", rsp_data, 32'h0);

    // 1: basic read, two busy polls
    start_scn(1, 0, 2, -1, 32'h1122_3344);
    run_req(32'h3000_0010, 1'b0, lat, d, e);
    chk("s1_latency", lat, 19);
    chk("s1_data", d, 32'h4433_2211);
    chk("s1_err", {31'b0, e}, 32'h0);
    check_read_prog(32'h0300_0010, 3);
    chk("s1_stable", stab_err, 0);

    // 2: write request is rejected without APB traffic
    start_scn(2, 0, 0, -1, 32'h0);
    run_req(32'h3000_0000, 1'b1, lat, d, e);
    chk("s2_latency", lat, 1);
    chk("s2_err", {31'b0, e}, 32'h1);
    chk("s2_data", d, 32'h0);
    chk("s2_no_apb", lg_addr.size(), 0);

    // 3: three wait states on every access
    start_scn(3, 3, 2, -1, 32'h1122_3344);
    run_req(32'h3000_0010, 1'b0, lat, d, e);
    chk("s3_latency", lat, 46);
    chk("s3_data", d, 32'h4433_2211);
    chk("s3_err", {31'b0, e}, 32'h0);
    check_read_prog(32'h0300_0010, 3);
    chk("s3_stable", stab_err, 0);

    // 4: slave error on the TX1 write
    start_scn(4, 0, 0, 2, 32'hDEAD_BEEF);
    run_req(32'h3000_0020, 1'b0, lat, d, e);
    chk("s4_latency", lat, 9);
    chk("s4_err", {31'b0, e}, 32'h1);
    chk("s4_data", d, 32'h0);
    chk("s4_acc_count", lg_addr.size(), 4);
    check_acc(0, BASE + 32'h14, 1'b1, 32'h1);
    check_acc(1, BASE + 32'h18, 1'b1, 32'h1);
    check_acc(2, BASE + 32'h04, 1'b1, 32'h0300_0020);
    check_acc(3, BASE + 32'h18, 1'b1, 32'h0);

    // 5: CTRL stays busy -> timeout after POLL_MAX+1 = 4 polls
    start_scn(5, 0, 1000000, -1, 32'h5555_AAAA);
    run_req(32'h3000_0100, 1'b0, lat, d, e);
    chk("s5_err", {31'b0, e}, 32'h1);
    chk("s5_data", d, 32'h0);
    chk("s5_acc_count", lg_addr.size(), 9);
    check_acc(3, BASE + 32'h10, 1'b1, 32'h2540);
    for (int p = 0; p < 4; p++) check_acc(4 + p, BASE + 32'h10, 1'b0, 32'h0);
    check_acc(8, BASE + 32'h18, 1'b1, 32'h0);

    // 6: reset asserted while polling, then a fresh read
    start_scn(6, 0, 1000000, -1, 32'h0);
    req_valid = 1'b1; req_addr = 32'h3000_0040; req_write = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(posedge clock); #1;
      if (out_psel && !out_pwrite && out_paddr == BASE + 32'h10) found = 1;
    end
    chk("s6_in_poll", found, 1);
    reset = 1'b0;
    #1;
    chk("s6_psel", {31'b0, out_psel}, 32'h0);
    chk("s6_penable", {31'b0, out_penable}, 32'h0);
    chk("s6_paddr", out_paddr, 32'h0);
    chk("s6_pwrite", {31'b0, out_pwrite}, 32'h0);
    chk("s6_pwdata", out_pwdata, 32'h0);
    chk("s6_pstrb", {28'b0, out_pstrb}, 32'h0);
    chk("s6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(negedge clock); reset = 1'b1;
    start_scn(7, 0, 0, -1, 32'hA1B2_C3D4);
    run_req(32'h3012_3457, 1'b0, lat, d, e);
    chk("s7_latency", lat, 15);
    chk("s7_data", d, 32'hD4C3_B2A1);
    chk("s7_err", {31'b0, e}, 32'h0);
    check_read_prog(32'h0312_3454, 1);
    chk("s7_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
